// File: rtl/sample_packetiser.sv
// sample_packetiser: buffers 16-bit filtered samples in a FIFO and frames them into byte packets
// (6-byte header, big-endian payload, optional checksum trailer enabled by SAMPLE_PKT_CHECKSUM_EN).
module sample_packetiser #(
    parameter int unsigned SAMPLES_PER_PKT = 8,
    parameter int unsigned FIFO_DEPTH      = 32,
    parameter logic [15:0] SYNC_WORD       = 16'hA55A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sample_in,
    input  logic        sample_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_sof,
    output logic        tx_eof,
    output logic [15:0] overflow_cnt,
    output logic [15:0] pkt_seq
);

    localparam int unsigned   AW       = $clog2(FIFO_DEPTH);
    localparam int unsigned   CW       = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] SPP_C    = CW'(SAMPLES_PER_PKT);
    localparam logic [7:0]    SPP_BYTE = 8'(SAMPLES_PER_PKT);
    localparam logic [7:0]    LAST_IDX = 8'(SAMPLES_PER_PKT - 1);

`ifdef SAMPLE_PKT_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, CSUM} state_t;
`else
    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;
`endif

    state_t        state;
    logic [2:0]    hdr_idx;
    logic [7:0]    samp_idx;
    logic          lsb_phase;
    logic          ovf_sticky;

    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          can_write;
    logic          do_write;
    logic          drop;
    logic          xfer;
    logic          pop;
    logic          hdr_done;
    logic          last_samp;
    logic [15:0]   head;
    logic [15:0]   head_next;
    logic [7:0]    hdr_next;

    // Handshake: a byte moves on a rising edge with tx_valid && tx_ready; while stalled
    // (tx_valid && !tx_ready) tx_data/tx_sof/tx_eof are held, and tx_valid stays high
    // from the first header byte to the final byte of the packet.
    assign xfer      = tx_valid && tx_ready;
    assign can_write = (count != DEPTH_C);
    assign do_write  = sample_valid && can_write;
    assign drop      = sample_valid && !can_write;
    assign pop       = (state == PAYLOAD) && lsb_phase && xfer;
    assign hdr_done  = (state == HDR) && (hdr_idx == 3'd5) && xfer;
    assign last_samp = (samp_idx == LAST_IDX);
    assign head      = mem[rd_ptr];
    assign head_next = mem[rd_ptr + AW'(1)];

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= sample_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_cnt <= 16'h0000;
            ovf_sticky   <= 1'b0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + AW'(1);
            if (pop)      rd_ptr <= rd_ptr + AW'(1);
            if (do_write && !pop)      count <= count + CW'(1);
            else if (!do_write && pop) count <= count - CW'(1);
            if (drop && overflow_cnt != 16'hFFFF) overflow_cnt <= overflow_cnt + 16'd1;
            // A drop in the same cycle the flags byte is consumed keeps the flag armed.
            if (drop)          ovf_sticky <= 1'b1;
            else if (hdr_done) ovf_sticky <= 1'b0;
        end
    end

    // Header byte that follows the one currently presented at hdr_idx.
    always_comb begin
        hdr_next = 8'h00;
        case (hdr_idx)
            3'd0:    hdr_next = SYNC_WORD[7:0];
            3'd1:    hdr_next = pkt_seq[15:8];
            3'd2:    hdr_next = pkt_seq[7:0];
            3'd3:    hdr_next = SPP_BYTE;
            3'd4:    hdr_next = {7'd0, ovf_sticky | drop};
            default: hdr_next = 8'h00;
        endcase
    end

`ifdef SAMPLE_PKT_CHECKSUM_EN
    logic [15:0] csum;
    logic [16:0] csum_raw;
    logic [15:0] csum_next;

    // Ones-complement accumulate with end-around carry of the sample being popped.
    always_comb begin
        csum_raw  = {1'b0, csum} + {1'b0, head};
        csum_next = csum_raw[15:0] + {15'd0, csum_raw[16]};
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            hdr_idx   <= 3'd0;
            samp_idx  <= 8'd0;
            lsb_phase <= 1'b0;
            tx_data   <= 8'h00;
            tx_valid  <= 1'b0;
            tx_sof    <= 1'b0;
            tx_eof    <= 1'b0;
            pkt_seq   <= 16'h0000;
`ifdef SAMPLE_PKT_CHECKSUM_EN
            csum      <= 16'h0000;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (count >= SPP_C) begin
                        state    <= HDR;
                        hdr_idx  <= 3'd0;
                        tx_data  <= SYNC_WORD[15:8];
                        tx_valid <= 1'b1;
                        tx_sof   <= 1'b1;
                        tx_eof   <= 1'b0;
`ifdef SAMPLE_PKT_CHECKSUM_EN
                        csum     <= 16'h0000;
`endif
                    end
                end
                HDR: begin
                    if (xfer) begin
                        tx_sof <= 1'b0;
                        if (hdr_idx == 3'd5) begin
                            state     <= PAYLOAD;
                            samp_idx  <= 8'd0;
                            lsb_phase <= 1'b0;
                            tx_data   <= head[15:8];
                        end else begin
                            hdr_idx <= hdr_idx + 3'd1;
                            tx_data <= hdr_next;
                        end
                    end
                end
                PAYLOAD: begin
                    if (xfer) begin
                        if (!lsb_phase) begin
                            lsb_phase <= 1'b1;
                            tx_data   <= head[7:0];
`ifdef SAMPLE_PKT_CHECKSUM_EN
                            tx_eof    <= 1'b0;
`else
                            tx_eof    <= last_samp;
`endif
                        end else if (last_samp) begin
`ifdef SAMPLE_PKT_CHECKSUM_EN
                            state   <= CSUM;
                            hdr_idx <= 3'd0;
                            csum    <= csum_next;
                            tx_data <= ~csum_next[15:8];
`else
                            state    <= IDLE;
                            tx_valid <= 1'b0;
                            tx_eof   <= 1'b0;
                            tx_data  <= 8'h00;
                            pkt_seq  <= pkt_seq + 16'd1;
`endif
                        end else begin
                            lsb_phase <= 1'b0;
                            samp_idx  <= samp_idx + 8'd1;
                            tx_data   <= head_next[15:8];
`ifdef SAMPLE_PKT_CHECKSUM_EN
                            csum      <= csum_next;
`endif
                        end
                    end
                end
`ifdef SAMPLE_PKT_CHECKSUM_EN
                CSUM: begin
                    if (xfer) begin
                        if (!hdr_idx[0]) begin
                            hdr_idx <= 3'd1;
                            tx_data <= ~csum[7:0];
                            tx_eof  <= 1'b1;
                        end else begin
                            state    <= IDLE;
                            tx_valid <= 1'b0;
                            tx_eof   <= 1'b0;
                            tx_data  <= 8'h00;
                            pkt_seq  <= pkt_seq + 16'd1;
                        end
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sample_packetiser.sv
// Directed bench for sample_packetiser: stimulus pushes expected bytes {sof,eof,data} into a
// queue, and a monitor pops/compares on every accepted byte. Honours SAMPLE_PKT_CHECKSUM_EN.
module tb_sample_packetiser;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_sof;
    logic        tx_eof;
    logic [15:0] overflow_cnt;
    logic [15:0] pkt_seq;

    int tests_run    = 0;
    int tests_failed = 0;
    int xfer_cnt     = 0;
    int stall_cnt    = 0;
    int ready_mode   = 0;

    logic [9:0] exp_q[$];
    logic [9:0] held;
    logic [9:0] got;
    logic       stall_prev = 1'b0;
    logic       in_pkt     = 1'b0;

    sample_packetiser dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_sof       (tx_sof),
        .tx_eof       (tx_eof),
        .overflow_cnt (overflow_cnt),
        .pkt_seq      (pkt_seq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // tx_ready driver: 0 = always ready, 1 = pseudo-random, 2 = never ready.
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = 1'($urandom_range(0, 1));
                default: tx_ready = 1'b0;
            endcase
        end
    end

    // Monitor: compares each accepted byte and checks hold-during-stall and no mid-packet gaps.
    always @(negedge clk) begin
        if (!rst) begin
            stall_prev = 1'b0;
            in_pkt     = 1'b0;
        end else begin
            got = {tx_sof, tx_eof, tx_data};
            if (stall_prev) check("stall_hold", 32'({tx_valid, got}), 32'({1'b1, held}));
            if (in_pkt) check("valid_in_pkt", 32'(tx_valid), 32'd1);
            if (tx_valid && tx_ready) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL unexpected_byte: got %0h expected none", got);
                end else begin
                    check("tx_byte", 32'(got), 32'(exp_q.pop_front()));
                end
                if (tx_sof) in_pkt = 1'b1;
                if (tx_eof) in_pkt = 1'b0;
            end
            stall_prev = tx_valid && !tx_ready;
            if (stall_prev) stall_cnt++;
            held = got;
        end
    end

    task automatic push_byte(input logic [7:0] b, input logic sof, input logic eof);
        exp_q.push_back({sof, eof, b});
    endtask

    task automatic push_pkt(input logic [15:0] seq, input logic [7:0] flags, input logic [15:0] s [8]);
        logic [16:0] acc;
        logic [15:0] sum;
        sum = 16'h0000;
        push_byte(8'hA5, 1'b1, 1'b0);
        push_byte(8'h5A, 1'b0, 1'b0);
        push_byte(seq[15:8], 1'b0, 1'b0);
        push_byte(seq[7:0], 1'b0, 1'b0);
        push_byte(8'h08, 1'b0, 1'b0);
        push_byte(flags, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            acc = {1'b0, sum} + {1'b0, s[i]};
            sum = acc[15:0] + {15'd0, acc[16]};
            push_byte(s[i][15:8], 1'b0, 1'b0);
`ifdef SAMPLE_PKT_CHECKSUM_EN
            push_byte(s[i][7:0], 1'b0, 1'b0);
`else
            push_byte(s[i][7:0], 1'b0, i == 7);
`endif
        end
`ifdef SAMPLE_PKT_CHECKSUM_EN
        sum = ~sum;
        push_byte(sum[15:8], 1'b0, 1'b0);
        push_byte(sum[7:0], 1'b0, 1'b1);
`endif
    endtask

    task automatic write_sample(input logic [15:0] v);
        @(posedge clk);
        #1;
        sample_valid = 1'b1;
        sample_in    = v;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain_timeout: %0d bytes outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
    endtask

    logic [15:0] s2 [8];
    logic [7:0]  t2 [22];
    logic [15:0] s4 [4][8];
    logic [15:0] s5a [8];
    logic [15:0] s5b [8];
    logic [15:0] pkt [8];
    int          start;

    initial begin
        s2 = '{16'h0064, 16'h00C8, 16'hFF6A, 16'hFC18, 16'h012C, 16'h0190, 16'hFED4, 16'h0000};
        t2 = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h08, 8'h00,
               8'h00, 8'h64, 8'h00, 8'hC8, 8'hFF, 8'h6A, 8'hFC, 8'h18,
               8'h01, 8'h2C, 8'h01, 8'h90, 8'hFE, 8'hD4, 8'h00, 8'h00};

        // Reset held with traffic present: nothing may be written or emitted.
        rst = 1'b0;
        sample_valid = 1'b1;
        sample_in = 16'h1234;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_sof", 32'(tx_sof), 32'd0);
        check("rst_tx_eof", 32'(tx_eof), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_overflow_cnt", 32'(overflow_cnt), 32'd0);
        check("rst_pkt_seq", 32'(pkt_seq), 32'd0);
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        rst = 1'b1;

        // Basic packet with hand-computed bytes, plus start latency.
        for (int i = 0; i < 22; i++) push_byte(t2[i], i == 0, (i == 21) && 1'b1);
`ifdef SAMPLE_PKT_CHECKSUM_EN
        exp_q[21] = {1'b0, 1'b0, 8'h00};
        push_byte(8'h01, 1'b0, 1'b0);
        push_byte(8'hBF, 1'b0, 1'b1);
`endif
        for (int i = 0; i < 7; i++) write_sample(s2[i]);
        idle_cycle();
        repeat (4) @(negedge clk);
        check("no_valid_below_n", 32'(tx_valid), 32'd0);
        write_sample(s2[7]);
        idle_cycle();
        @(negedge clk);
        check("latency_edge_t", 32'(tx_valid), 32'd0);
        @(negedge clk);
        check("latency_edge_t1", 32'(tx_valid), 32'd1);
        wait_drain(200);
        check("seq_after_basic", 32'(pkt_seq), 32'd1);

        // Same samples under random backpressure.
        push_pkt(16'd1, 8'h00, s2);
        ready_mode = 1;
        for (int i = 0; i < 8; i++) write_sample(s2[i]);
        idle_cycle();
        wait_drain(600);
        ready_mode = 0;
        check("stalls_seen", 32'(stall_cnt > 0), 32'd1);
        check("seq_after_bp", 32'(pkt_seq), 32'd2);

        // Overflow: 40 samples into a 32-deep FIFO with the sink stalled.
        ready_mode = 2;
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 8; i++) begin
                s4[p][i] = 16'((p * 8 + i) * 1111 + 7);
                pkt[i] = s4[p][i];
            end
            push_pkt(16'(2 + p), (p == 0) ? 8'h01 : 8'h00, pkt);
        end
        for (int i = 0; i < 40; i++) write_sample(16'(i * 1111 + 7));
        idle_cycle();
        repeat (2) @(negedge clk);
        check("overflow_cnt_8", 32'(overflow_cnt), 32'd8);
        check("stalled_valid", 32'(tx_valid), 32'd1);
        check("stalled_sof", 32'(tx_sof), 32'd1);
        ready_mode = 0;
        wait_drain(600);
        check("seq_after_ovf", 32'(pkt_seq), 32'd6);
        check("overflow_cnt_hold", 32'(overflow_cnt), 32'd8);

        // Reset while payload byte 10 is presented, then a clean packet.
        for (int i = 0; i < 8; i++) begin
            s5a[i] = 16'h1000 + 16'(i * 16'h0111);
            s5b[i] = 16'h8000 - 16'(i * 16'h0203);
        end
        push_pkt(16'd6, 8'h00, s5a);
        for (int i = 0; i < 8; i++) write_sample(s5a[i]);
        idle_cycle();
        start = xfer_cnt;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (xfer_cnt - start >= 10) break;
        end
        check("reach_byte10", 32'(xfer_cnt - start), 32'd10);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_tx_valid", 32'(tx_valid), 32'd0);
        check("midrst_tx_sof", 32'(tx_sof), 32'd0);
        check("midrst_pkt_seq", 32'(pkt_seq), 32'd0);
        check("midrst_overflow", 32'(overflow_cnt), 32'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_idle", 32'(tx_valid), 32'd0);
        push_pkt(16'd0, 8'h00, s5b);
        for (int i = 0; i < 8; i++) write_sample(s5b[i]);
        idle_cycle();
        wait_drain(200);
        check("seq_after_midrst", 32'(pkt_seq), 32'd1);

`ifdef SAMPLE_PKT_CHECKSUM_EN
        // Eight samples of 1: checksum is ~0x0008 = FFF7.
        push_byte(8'hA5, 1'b1, 1'b0);
        push_byte(8'h5A, 1'b0, 1'b0);
        push_byte(8'h00, 1'b0, 1'b0);
        push_byte(8'h01, 1'b0, 1'b0);
        push_byte(8'h08, 1'b0, 1'b0);
        push_byte(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            push_byte(8'h00, 1'b0, 1'b0);
            push_byte(8'h01, 1'b0, 1'b0);
        end
        push_byte(8'hFF, 1'b0, 1'b0);
        push_byte(8'hF7, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) write_sample(16'h0001);
        idle_cycle();
        wait_drain(200);
        check("seq_after_csum", 32'(pkt_seq), 32'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sample_packetiser.md
Name: sample_packetiser

Overview:
- Sits directly downstream of the FIR filter stage and consumes its 16-bit signed filtered samples.
- Buffers the samples in an internal FIFO and frames every SAMPLES_PER_PKT samples into a byte-stream packet: header, big-endian payload, and an optional checksum.
- The byte stream uses a valid/ready handshake and feeds the Ethernet MAC/UDP framer.

Parameters:
- SAMPLES_PER_PKT, 8, samples per packet; legal range 1..255; also sent in header byte 4.
- FIFO_DEPTH, 32, sample FIFO depth; power of 2; must be >= SAMPLES_PER_PKT.
- SYNC_WORD, 16'hA55A, packet sync word, sent MSB first.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- sample_in  input  16  signed filtered sample.
- sample_valid  input  1  sample_in valid this cycle; no backpressure toward the filter.
- tx_data  output  8  packet byte.
- tx_valid  output  1  tx_data valid.
- tx_ready  input  1  downstream accepts the byte.
- tx_sof  output  1  first byte of packet; qualified by tx_valid.
- tx_eof  output  1  last byte of packet; qualified by tx_valid.
- overflow_cnt  output  16  count of dropped samples; saturates at 16'hFFFF.
- pkt_seq  output  16  sequence number of the next/current packet.

Behaviour:
- Reset (asynchronous, rst=0):
  - FIFO emptied, FSM to IDLE.
  - tx_valid, tx_sof, tx_eof, tx_data, overflow_cnt and pkt_seq all 0.
  - Sticky overflow flag cleared.
  - Reset asserted mid-packet aborts the packet immediately; no partial completion after release.
- FIFO write:
  - On a clk edge with sample_valid=1 and occupancy < FIFO_DEPTH at the start of the cycle, the sample is written.
  - This holds even if a pop happens in the same cycle.
  - Otherwise the sample is dropped: overflow_cnt increments (saturating) and the sticky overflow flag is set.
- Handshake:
  - A byte transfers on a clk edge with tx_valid && tx_ready.
  - While tx_valid=1 and tx_ready=0, tx_data, tx_sof and tx_eof hold stable.
  - tx_valid never drops mid-packet.
- FSM states: IDLE, HDR, PAYLOAD, CSUM (CSUM exists only with the optional feature).
- IDLE:
  - When occupancy >= SAMPLES_PER_PKT, go to HDR on the next edge.
  - Latency: occupancy reaches N at edge t; tx_valid=1 after edge t+1.
- HDR, 6 bytes in order:
  - SYNC_WORD[15:8], SYNC_WORD[7:0]
  - pkt_seq[15:8], pkt_seq[7:0]
  - SAMPLES_PER_PKT[7:0]
  - flags: bit0 = sticky overflow, bits 7:1 = 0
  - tx_sof=1 on byte 0.
  - The sticky flag clears when byte 5 transfers. An overflow in that same cycle keeps it set (set wins).
- PAYLOAD:
  - 2*SAMPLES_PER_PKT bytes, each sample MSB first, read from the FIFO head (show-ahead).
  - A sample pops when its LSB byte transfers.
  - FIFO writes continue concurrently.
- End of packet:
  - tx_eof marks the final byte (last payload LSB, or last CSUM byte when enabled).
  - On transfer of the final byte: pkt_seq increments (wraps 16'hFFFF to 0) and FSM returns to IDLE.
  - Back-to-back packets leave one idle cycle (IDLE state) between them.
- Packet length: 6 + 2*SAMPLES_PER_PKT bytes, plus 2 with the checksum.

Optional Feature:
- Macro: SAMPLE_PKT_CHECKSUM_EN.
- Defined:
  - Adds CSUM state after PAYLOAD.
  - Running 16-bit ones-complement sum (end-around carry) of the payload sample words, cleared in HDR.
  - Transmits the inverted sum MSB then LSB; tx_eof on the LSB.
- Undefined:
  - No CSUM state or accumulator logic.
  - tx_eof on the last payload byte.

Test Plan:
1. Reset: hold rst=0 with sample_valid=1 and tx_ready=1 -> all outputs 0 and no FIFO writes. Release -> tx_valid stays 0 until 8 samples are written.
2. Basic packet (feature off, tx_ready=1): write samples 100, 200, -150, -1000, 300, 400, -300, 0 -> 22 bytes:
   - A5 5A 00 00 08 00
   - 00 64 00 C8 FF 6A FC 18 01 2C 01 90 FE D4 00 00
   - tx_sof on byte 0, tx_eof on byte 21.
   - pkt_seq = 1 afterward.
3. Backpressure: same stimulus with tx_ready toggling pseudo-randomly -> identical byte sequence; tx_data, tx_sof and tx_eof stable during every stall.
4. Overflow: tx_ready=0, write 40 consecutive samples -> overflow_cnt=8. Raise tx_ready -> header flags byte = 01. Following packet flags byte = 00 if no new drops.
5. Mid-packet reset: assert rst during payload byte 10 -> tx_valid=0 immediately. After release: pkt_seq=0, FIFO empty, next packet starts with a full header.
6. Checksum (SAMPLE_PKT_CHECKSUM_EN defined): eight samples of 0x0001 -> 24-byte packet ending FF F7, tx_eof on F7.
